tank_sprite_reader: RTL
=======================

Name: tank_sprite_reader

Overview:
- Read-side client of the 128x16 tank sprite ROMs (colour variants such as purple).
- Each ROM holds 8 frames of 16x16 pixels with 4-bit palette indices.
- Per VGA pixel, the block decides whether the scan position lies inside one tank's 16x16 box, forms the ROM row address from latched direction and animation frame, selects the pixel column, and returns a palette index plus a valid (non-transparent) flag to the colour mapper.
- Direction, enable and animation frame are latched only at frame boundaries, so a sprite never tears mid-frame.

Parameters:
- ANIM_DIV, 4, number of frame_tick pulses between animation-frame toggles while moving (legal range 1..15).
- SPR_SIZE, 16, sprite edge in pixels; fixed at 16, present for documentation and assertions only.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  single-cycle pulse at start of vertical blank.
- DrawX  in  10  current scan column, 0..639.
- DrawY  in  10  current scan row, 0..479.
- tank_x  in  10  sprite top-left column.
- tank_y  in  10  sprite top-left row.
- dir_in  in  2  0=left, 1=up, 2=right, 3=down.
- moving  in  1  tank moved this frame.
- enable_in  in  1  tank alive/visible.
- rom_row_addr  out  7  row index to sprite ROM.
- rom_row  in  64  ROM row data, combinational from rom_row_addr; pixel c at bits [63-4c -: 4], c=0 leftmost.
- pixel_out  out  4  palette index, 0 = transparent.
- pixel_valid  out  1  pixel_out is non-zero and inside the sprite box.
- anim_frame  out  1  currently latched animation frame (debug).

Behaviour:
- Reset (async, Reset_n=0): all registers clear. This includes rom_row_addr=0, pixel_out=0, pixel_valid=0, anim_frame=0, dir_q=0, en_q=0 and anim_cnt=0.
- Frame latch, on a cycle with frame_tick=1:
  - dir_q<=dir_in and en_q<=enable_in.
  - If moving=1 and anim_cnt==ANIM_DIV-1: anim_cnt<=0 and anim_frame toggles.
  - Else if moving=1: anim_cnt increments.
  - If moving=0: anim_cnt and anim_frame hold.
  - Outside frame_tick, these registers hold.
- Stage 0 (registered, cycle N):
  - dx = {1'b0,DrawX}-{1'b0,tank_x} and dy likewise, both 11-bit.
  - hit0 = en_q & dx<16 & dy<16 (unsigned). DrawX<tank_x yields a large unsigned dx, so hit0=0; there is no wrap-around hit.
  - rom_row_addr <= {dir_q, anim_frame, dy[3:0]}.
  - col_q <= dx[3:0] and hit_q <= hit0.
  - rom_row_addr updates every cycle regardless of hit.
- Stage 1 (registered, cycle N+1):
  - p = rom_row[63-4*col_q -: 4].
  - pixel_out <= hit_q ? p : 0.
  - pixel_valid <= hit_q & (p!=0).
- Latency: DrawX/DrawY presented at cycle N produce pixel_out/pixel_valid at the output after the edge ending cycle N+1, i.e. 2 clocks. The pipeline is fully streaming, one pixel per clock, with no stalls.
- Same-cycle events:
  - A frame_tick in the same cycle as a stage-0 evaluation: stage 0 uses the pre-update dir_q/anim_frame values.
  - Changes to tank_x/tank_y take effect immediately, with no frame latching; the game logic updates them during blanking.
- Reset mid-line: the pipeline flushes to zero outputs and resumes correct output 2 clocks after Reset_n deasserts.
- ANIM_DIV=1 toggles anim_frame on every frame_tick while moving.

Test Plan:
- Hit, opaque pixel: reset, then frame_tick with dir_in=0, enable_in=1, moving=0; tank=(100,50); DrawX=107, DrawY=57 -> rom_row_addr=7, pixel_out=7, pixel_valid=1 two clocks later.
- Hit, transparent pixel: DrawX=100, DrawY=50, same setup -> rom_row_addr=0, pixel_out=0, pixel_valid=0.
- Direction latch: dir_in=1 changed mid-frame with no frame_tick -> address still uses dir 0. After frame_tick, DrawX=107, DrawY=52 -> rom_row_addr=34, pixel_out=5, valid=1.
- Animation: ANIM_DIV=4, moving=1, 4 frame_ticks -> anim_frame=1 after the 4th tick. dir 2 at dy=7 -> rom_row_addr=87. With moving=0 for 10 ticks, anim_frame stays 1.
- Box boundaries: tank=(0,0), DrawX=639, DrawY=0 -> no hit. DrawX=15, DrawY=15 -> hit. DrawX=16 -> valid=0. enable_in=0 latched -> valid=0 everywhere.
- Reset mid-stream: streaming hits at 1 pixel/clock, then assert Reset_n=0 asynchronously -> outputs 0 immediately. Deassert -> en_q=0, so no valid pixel until the next frame_tick with enable_in=1.

Source files
------------

// File: rtl/tank_sprite_reader.sv
// -----------------------------------------------------------------------------
// tank_sprite_reader
//
// Read-side client of a 128x16 tank sprite ROM (8 frames of 16x16 pixels,
// 4-bit palette indices, one 64-bit row per address). For every VGA pixel it
// decides whether the scan position falls inside the tank's 16x16 box, drives
// the ROM row address built from the latched direction and animation frame,
// picks the pixel column out of the returned row and hands a palette index
// plus a non-transparent flag to the colour mapper.
//
// Direction, enable and animation frame only change on frame_tick, so a
// sprite can never tear partway down the screen.
//
// Ports:
//   Clk          in   1   pixel clock
//   Reset_n      in   1   asynchronous active-low reset
//   frame_tick   in   1   one-cycle pulse at start of vertical blank
//   DrawX/DrawY  in  10   current scan column/row
//   tank_x/y     in  10   sprite top-left corner (not frame-latched)
//   dir_in       in   2   0=left 1=up 2=right 3=down
//   moving       in   1   tank moved this frame (advances animation)
//   enable_in    in   1   tank alive/visible
//   rom_row_addr out  7   {dir, anim_frame, row} to the sprite ROM
//   rom_row      in  64   ROM row data, pixel c at [63-4c -: 4]
//   pixel_out    out  4   palette index, 0 = transparent
//   pixel_valid  out  1   pixel_out non-zero and inside the box
//   anim_frame   out  1   latched animation frame
//
// Latency is two clocks from DrawX/DrawY to pixel_out/pixel_valid; the
// pipeline accepts one pixel every clock and never stalls.
// -----------------------------------------------------------------------------
module tank_sprite_reader #(
  parameter int unsigned ANIM_DIV = 4,  // frame_ticks per animation toggle (1..15)
  parameter int unsigned SPR_SIZE = 16  // sprite edge, fixed at 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [1:0]  dir_in,
  input  logic        moving,
  input  logic        enable_in,
  output logic [6:0]  rom_row_addr,
  input  logic [63:0] rom_row,
  output logic [3:0]  pixel_out,
  output logic        pixel_valid,
  output logic        anim_frame
);

  localparam logic [3:0]  ANIM_LAST = 4'(ANIM_DIV - 1);
  localparam logic [10:0] SPR_EDGE  = 11'(SPR_SIZE);

  // Frame-latched state
  logic [1:0] dir_q, dir_d;
  logic       en_q, en_d;
  logic [3:0] anim_cnt_q, anim_cnt_d;
  logic       anim_q, anim_d;

  // Stage 0 state
  logic [6:0] addr_q, addr_d;
  logic [3:0] col_q, col_d;
  logic       hit_q, hit_d;

  // Stage 1 state
  logic [3:0] pix_q, pix_d;
  logic       valid_q, valid_d;

  // Stage 0 / stage 1 intermediates
  logic [10:0] dx, dy;
  logic [63:0] row_shifted;
  logic [3:0]  p;

  // Next-state for direction, enable and animation, updated only on frame_tick
  always_comb begin
    dir_d      = dir_q;
    en_d       = en_q;
    anim_cnt_d = anim_cnt_q;
    anim_d     = anim_q;
    if (frame_tick) begin
      dir_d = dir_in;
      en_d  = enable_in;
      if (moving) begin
        if (anim_cnt_q == ANIM_LAST) begin
          anim_cnt_d = 4'd0;
          anim_d     = ~anim_q;
        end else begin
          anim_cnt_d = anim_cnt_q + 4'd1;
        end
      end else begin
        anim_cnt_d = anim_cnt_q;
        anim_d     = anim_q;
      end
    end else begin
      dir_d = dir_q;
      en_d  = en_q;
    end
  end

  // Stage 0: box test and ROM row address. The 11-bit subtraction makes a scan
  // position left of / above the tank wrap to a large value, so it never hits.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, tank_x};
    dy     = {1'b0, DrawY} - {1'b0, tank_y};
    hit_d  = en_q & (dx < SPR_EDGE) & (dy < SPR_EDGE);
    addr_d = {dir_q, anim_q, dy[3:0]};
    col_d  = dx[3:0];
  end

  // Stage 1: pick the column out of the ROM row and qualify it with the hit
  always_comb begin
    // Leftmost pixel lives in the top nibble, so shift the wanted one up there
    row_shifted = rom_row << {col_q, 2'b00};
    p           = row_shifted[63:60];
    if (hit_q) begin
      pix_d   = p;
      valid_d = (p != 4'd0);
    end else begin
      pix_d   = 4'd0;
      valid_d = 1'b0;
    end
  end

  // All pipeline and frame-latched registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_q      <= 2'd0;
      en_q       <= 1'b0;
      anim_cnt_q <= 4'd0;
      anim_q     <= 1'b0;
      addr_q     <= 7'd0;
      col_q      <= 4'd0;
      hit_q      <= 1'b0;
      pix_q      <= 4'd0;
      valid_q    <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      en_q       <= en_d;
      anim_cnt_q <= anim_cnt_d;
      anim_q     <= anim_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      hit_q      <= hit_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_row_addr = addr_q;
  assign pixel_out    = pix_q;
  assign pixel_valid  = valid_q;
  assign anim_frame   = anim_q;

endmodule
